// File: rtl/e6_mon_pkg.sv
// Shared types for the e6 output monitor: the controller's output word,
// the capture-window state machine encoding and the event record layout.
package e6_mon_pkg;

  localparam int Y_W      = 20;
  localparam int DEF_TS_W = 12;

  typedef logic [Y_W-1:0] y_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Record at the default timestamp width; the top level declares the same
  // layout at whatever TS_W it is built with. Timestamp sits in the MSBs.
  typedef struct packed {
    logic [DEF_TS_W-1:0] ts;
    y_t                  y;
  } rec_t;

endpackage

// File: rtl/e6_out_monitor_fifo.sv
// Small synchronous FIFO for event records. Pointers carry an extra wrap bit
// so full and empty are told apart without a separate counter. The head entry
// is kept in a register so the sink sees a flop output, not a memory read.
module mon_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr, wptr_nxt, rptr_nxt;
  logic         do_wr, do_rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && !flush && (!full || do_rd);

  // Pointer advance for this cycle's accepted read and write
  always_comb begin
    wptr_nxt = do_wr ? wptr + 1'b1 : wptr;
    rptr_nxt = do_rd ? rptr + 1'b1 : rptr;
  end

  // Pointer registers; flush empties the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_nxt;
      rptr <= rptr_nxt;
    end
  end

  // Storage array, written at the current write pointer
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wptr[AW-1:0]] <= wr_data;
  end

  // Head register: bypass the incoming word when it becomes the new head
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_data <= '0;
    else if (flush || (rptr_nxt == wptr_nxt))
      rd_data <= '0;
    else if (do_wr && (rptr_nxt == wptr))
      rd_data <= wr_data;
    else
      rd_data <= mem[rptr_nxt[AW-1:0]];
  end

endmodule

// File: rtl/e6_out_monitor.sv
// Capture stage for the e6 controller outputs. Every new non-zero output word
// seen during a capture window becomes a timestamped record in a FIFO that is
// drained over a valid/ready port. Records that do not fit are counted.
module e6_out_monitor
  import e6_mon_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TS_W   = 12,
  parameter int DROP_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [Y_W-1:0]      y_in,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TS_W+Y_W-1:0] out_data,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_cnt
);

  typedef struct packed {
    logic [TS_W-1:0] ts;
    y_t              y;
  } mon_rec_t;

  state_t          state_q, state_nxt;
  logic            busy_nxt, done_nxt;
  logic [TS_W-1:0] ts_q;
  y_t              prev_y;
  logic            fifo_full, fifo_empty;
  logic            evt, push, pop, drop;
  mon_rec_t        rec;

  assign evt       = (state_q == RUN) && (y_in != '0) && (y_in != prev_y);
  assign push      = evt && !clear;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push && fifo_full && !pop;
  assign rec.ts    = ts_q;
  assign rec.y     = y_in;

  // State register plus the registered busy/done decodes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next state: each state only listens to the control input that is legal in it
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start)      state_nxt = RUN;
      RUN:     if (stop)       state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Output decode, registered by the state process above
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_q == DRAIN) && (state_nxt == IDLE);
  end

  // Free-running timestamp, realigned to zero when a window opens
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ts_q <= '0;
    else if ((state_q == IDLE) && start)
      ts_q <= '0;
    else
      ts_q <= ts_q + 1'b1;
  end

  // Previous output word, tracked in every state so the first word of a window compares correctly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      prev_y <= '0;
    else
      prev_y <= y_in;
  end

  // Overflow accounting; clear wins over a drop in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  mon_fifo #(
    .DEPTH(DEPTH),
    .W    (TS_W + Y_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (clear),
    .wr_en  (push),
    .wr_data(rec),
    .rd_en  (pop),
    .rd_data(out_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_e6_out_monitor.sv
// Randomised and directed bench for e6_out_monitor with a queue-based
// reference model and a decoupled output monitor.
module tb_e6_out_monitor;

  localparam int DEPTH  = 8;
  localparam int TS_W   = 4;
  localparam int DROP_W = 8;
  localparam int RW     = TS_W + 20;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [19:0]       y_in;
  logic              start, stop, clear, out_ready;
  logic              out_valid, busy, done, overflow;
  logic [RW-1:0]     out_data;
  logic [DROP_W-1:0] drop_cnt;

  int compared   = 0;
  int mismatched = 0;
  int rec_seen   = 0;

  int          mdl_mode, mdl_cnt, mdl_ts, mdl_drops;
  logic [19:0] mdl_prev;
  logic        mdl_ovf, mdl_busy, mdl_done;
  logic [RW-1:0] exp_q[$];

  e6_out_monitor #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .y_in     (y_in),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    mdl_mode  = M_IDLE;
    mdl_cnt   = 0;
    mdl_ts    = 0;
    mdl_drops = 0;
    mdl_prev  = '0;
    mdl_ovf   = 1'b0;
    mdl_busy  = 1'b0;
    mdl_done  = 1'b0;
  endfunction

  // One clock edge of the behavioural model, using the inputs seen at that edge
  function automatic void model_step();
    bit pop, evt, done_n;
    int next_mode;
    pop = (mdl_cnt > 0) && out_ready;
    evt = (mdl_mode == M_RUN) && (y_in != 0) && (y_in != mdl_prev);
    next_mode = mdl_mode;
    if (mdl_mode == M_IDLE && start)            next_mode = M_RUN;
    else if (mdl_mode == M_RUN && stop)         next_mode = M_DRAIN;
    else if (mdl_mode == M_DRAIN && mdl_cnt == 0) next_mode = M_IDLE;
    done_n = (mdl_mode == M_DRAIN) && (next_mode == M_IDLE);
    if (clear) begin
      exp_q.delete();
      mdl_cnt   = 0;
      mdl_ovf   = 1'b0;
      mdl_drops = 0;
    end else begin
      if (pop) mdl_cnt--;
      if (evt) begin
        if (mdl_cnt < DEPTH) begin
          exp_q.push_back({mdl_ts[TS_W-1:0], y_in});
          mdl_cnt++;
        end else begin
          mdl_ovf = 1'b1;
          if (mdl_drops < (1 << DROP_W) - 1) mdl_drops++;
        end
      end
    end
    mdl_ts   = (mdl_mode == M_IDLE && start) ? 0 : (mdl_ts + 1) % (1 << TS_W);
    mdl_prev = y_in;
    mdl_mode = next_mode;
    mdl_busy = (next_mode != M_IDLE);
    mdl_done = done_n;
  endfunction

  task automatic apply_stimulus(input logic [19:0] y, input logic st, input logic sp,
                                input logic cl, input logic rd);
    @(negedge clk);
    y_in = y; start = st; stop = sp; clear = cl; out_ready = rd;
    @(posedge clk);
    if (rst) model_step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1; y_in = '0; start = 0; stop = 0; clear = 0; out_ready = 0;
    @(posedge clk);
    model_step();
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_out_valid"}, out_valid, 0);
    check_output({tag, "_out_data"}, out_data, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_overflow"}, overflow, 0);
    check_output({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  task automatic wait_idle(input int max_cycles, input bit toggle, output int pulses);
    pulses = 0;
    for (int i = 0; i < max_cycles; i++) begin
      apply_stimulus(y_in, 0, 0, 0, toggle ? ((i % 2) == 0) : 1'b1);
      #1;
      if (done) pulses++;
      if (!busy) break;
    end
    check_output("wait_idle_busy", busy, 0);
  endtask

  task automatic push_words(input int n, input logic [19:0] base, input logic rd);
    for (int k = 0; k < n; k++)
      apply_stimulus(base + 20'(k) + 20'd1, 0, 0, 0, rd);
  endtask

  // Output monitor: compares status against the model and pops on each handshake
  initial begin
    logic [RW-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      check_output("out_valid", out_valid, exp_q.size() != 0);
      check_output("busy", busy, mdl_busy);
      check_output("done", done, mdl_done);
      check_output("overflow", overflow, mdl_ovf);
      check_output("drop_cnt", drop_cnt, mdl_drops);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        rec_seen++;
        exp = exp_q.pop_front();
        check_output("out_data", out_data, exp);
      end
    end
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses, rec0;
    logic [19:0] ry;
    model_reset();
    rst = 1'b0; y_in = '0; start = 0; stop = 0; clear = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    release_reset();

    $display("[TB] basic capture with repeated word");
    rec0 = rec_seen;
    apply_stimulus(20'h0, 1, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      ry = (k == 3 || k == 4) ? 20'h00040 : (k == 5) ? 20'h00101 : 20'h0;
      apply_stimulus(ry, 0, 0, 0, 1);
    end
    apply_stimulus(20'h0, 0, 1, 0, 1);
    wait_idle(20, 0, pulses);
    check_output("basic_record_count", rec_seen - rec0, 2);

    $display("[TB] overflow, full push+pop, ordered drain");
    apply_stimulus(20'h0, 1, 0, 0, 0);
    push_words(10, 20'h01000, 0);
    #1;
    check_output("ovf_flag", overflow, 1);
    check_output("ovf_drop_cnt", drop_cnt, 2);
    apply_stimulus(20'h02222, 0, 0, 0, 1);
    #1;
    check_output("fullpp_drop_cnt", drop_cnt, 2);
    for (int k = 0; k < 12; k++) apply_stimulus(20'h02222, 0, 0, 0, 1);
    apply_stimulus(20'h0, 0, 1, 0, 1);
    wait_idle(20, 0, pulses);

    $display("[TB] stop with records queued, ready toggling");
    apply_stimulus(20'h0, 1, 0, 0, 0);
    push_words(3, 20'h03000, 0);
    apply_stimulus(20'h0, 0, 1, 0, 0);
    wait_idle(30, 1, pulses);
    check_output("drain_done_pulses", pulses, 1);

    $display("[TB] timestamp wrap");
    apply_stimulus(20'h0, 1, 0, 0, 1);
    for (int k = 0; k < 18; k++) begin
      ry = (k == 15) ? 20'h00005 : (k == 16) ? 20'h00006 : 20'h0;
      apply_stimulus(ry, 0, 0, 0, 1);
    end
    apply_stimulus(20'h0, 0, 1, 0, 1);
    wait_idle(20, 0, pulses);

    $display("[TB] clear while full, clear in drain");
    apply_stimulus(20'h0, 1, 0, 0, 0);
    push_words(10, 20'h04000, 0);
    apply_stimulus(20'h05555, 0, 0, 1, 0);
    #1;
    check_output("clear_out_valid", out_valid, 0);
    check_output("clear_overflow", overflow, 0);
    check_output("clear_drop_cnt", drop_cnt, 0);
    push_words(3, 20'h06000, 0);
    apply_stimulus(20'h0, 0, 1, 0, 0);
    apply_stimulus(20'h0, 0, 0, 1, 0);
    wait_idle(5, 0, pulses);
    check_output("clear_drain_done", pulses, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: ry = 20'h0;
        1: ry = y_in;
        2: ry = 20'h00040;
        3: ry = 20'h00101;
        default: ry = 20'($urandom);
      endcase
      apply_stimulus(ry, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);
    end
    apply_stimulus(y_in, 0, 1, 0, 1);
    wait_idle(40, 0, pulses);

    $display("[TB] reset in the middle of a window");
    apply_stimulus(20'h0, 1, 0, 0, 0);
    push_words(4, 20'h07000, 0);
    #3;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    apply_stimulus(20'h00011, 0, 0, 0, 1);
    release_reset();
    for (int k = 0; k < 4; k++) apply_stimulus(20'h0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
